// File: rtl/br_resolve.sv
// LC-3 branch-resolution stage: captures IR/PC on Start, waits for stable NZP,
// computes BEN and the next PC, pulses LD_PC/Done, and keeps branch statistics.
module br_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [15:0]      IR,
  input  logic [15:0]      PC,
  input  logic [2:0]       NZP,
  input  logic             Load_CC,
  input  logic             Clr_Stats,
  output logic             BEN,
  output logic [15:0]      PC_Next,
  output logic             LD_PC,
  output logic             Done,
  output logic             Busy,
  output logic             Err,
  output logic [CNT_W-1:0] Br_Cnt,
  output logic [CNT_W-1:0] Taken_Cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      pc_next_q, pc_next_d;
  logic             ben_q, ben_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             is_br;
  logic             ben_eval;
  logic [15:0]      offset_sext;
  logic [15:0]      target;
  logic             done_w;

  assign is_br       = (ir_q[15:12] == 4'b0000);
  assign ben_eval    = is_br && (|(ir_q[11:9] & NZP));
  assign offset_sext = {{7{ir_q[8]}}, ir_q[8:0]};
  // 16-bit sum: wrap-around past 0xFFFF is the intended LC-3 behaviour.
  assign target      = pc_q + offset_sext;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pc_d        = pc_q;
    ben_d       = ben_q;
    pc_next_d   = pc_next_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          ir_d    = IR;
          pc_d    = PC;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        // NZP is only trusted once the CC register has finished loading.
        if (!Load_CC) begin
          ben_d     = ben_eval;
          pc_next_d = ben_eval ? target : pc_q;
          if (is_br) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
            if (ben_eval && !(&taken_cnt_q)) begin
              taken_cnt_d = taken_cnt_q + CNT_ONE;
            end
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (Clr_Stats) begin
      br_cnt_d    = '0;
      taken_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      pc_q        <= '0;
      pc_next_q   <= '0;
      ben_q       <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      pc_next_q   <= pc_next_d;
      ben_q       <= ben_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // Pulses decode straight from the DONE state; BEN is already 0 for non-BR.
  assign done_w    = (state_q == S_DONE);
  assign Done      = done_w;
  assign LD_PC     = done_w && ben_q;
  assign Err       = done_w && !is_br;
  assign Busy      = (state_q != S_IDLE);
  assign BEN       = ben_q;
  assign PC_Next   = pc_next_q;
  assign Br_Cnt    = br_cnt_q;
  assign Taken_Cnt = taken_cnt_q;

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: directed vector table, corner sequences
// and randomized transactions against a transaction-level reference model.
module tb_br_resolve;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] IR;
  logic [15:0] PC;
  logic [2:0]  NZP;
  logic        Load_CC;
  logic        Clr_Stats;

  logic        BEN, LD_PC, Done, Busy, Err;
  logic [15:0] PC_Next;
  logic [15:0] Br_Cnt, Taken_Cnt;

  logic        d4_ben, d4_ld_pc, d4_done, d4_busy, d4_err;
  logic [15:0] d4_pc_next;
  logic [3:0]  d4_br_cnt, d4_taken_cnt;

  int checks = 0;
  int fails  = 0;

  // Reference model state: totals since last clear, independent of width.
  int br_total    = 0;
  int taken_total = 0;

  br_resolve #(.CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR(IR), .PC(PC), .NZP(NZP),
    .Load_CC(Load_CC), .Clr_Stats(Clr_Stats), .BEN(BEN), .PC_Next(PC_Next),
    .LD_PC(LD_PC), .Done(Done), .Busy(Busy), .Err(Err),
    .Br_Cnt(Br_Cnt), .Taken_Cnt(Taken_Cnt)
  );

  br_resolve #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR(IR), .PC(PC), .NZP(NZP),
    .Load_CC(Load_CC), .Clr_Stats(Clr_Stats), .BEN(d4_ben), .PC_Next(d4_pc_next),
    .LD_PC(d4_ld_pc), .Done(d4_done), .Busy(d4_busy), .Err(d4_err),
    .Br_Cnt(d4_br_cnt), .Taken_Cnt(d4_taken_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [2:0]  nzp;
    int          stall;
    bit          ben;
    logic [15:0] pcn;
    bit          err;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: decode offset by plain integer arithmetic.
  task automatic model(input logic [15:0] ir, input logic [15:0] pc, input logic [2:0] nzp,
                       output bit ben, output logic [15:0] pcn, output bit err);
    int off;
    int sum;
    err = (ir[15:12] != 4'd0);
    ben = !err && ((ir[11:9] & nzp) != 3'd0);
    off = int'(ir[8:0]);
    if (off >= 256) off = off - 512;
    sum = (int'(pc) + off + 65536) % 65536;
    pcn = ben ? sum[15:0] : pc;
  endtask

  task automatic check_cnts(input string tag);
    int t16;
    int t4;
    t16 = (taken_total > 65535) ? 65535 : taken_total;
    t4  = (taken_total > 15) ? 15 : taken_total;
    check({tag, "_br16"},    32'(Br_Cnt),       32'(br_total % 65536));
    check({tag, "_taken16"}, 32'(Taken_Cnt),    32'(t16));
    check({tag, "_br4"},     32'(d4_br_cnt),    32'(br_total % 16));
    check({tag, "_taken4"},  32'(d4_taken_cnt), 32'(t4));
  endtask

  // One complete resolution. Inputs are scrambled after capture to prove they
  // are ignored; 'noise' toggles Start while busy.
  task automatic run_txn(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                         input logic [2:0] nzp, input int stall, input bit noise,
                         input bit clr, input bit exp_ben, input logic [15:0] exp_pcn,
                         input bit exp_err);
    Start   = 1'b1;
    IR      = ir;
    PC      = pc;
    NZP     = 3'($urandom);
    Load_CC = (stall > 0);
    step();
    Start = noise ? 1'($urandom) : 1'b0;
    IR    = 16'($urandom);
    PC    = 16'($urandom);
    check({tag, "_busy_eval"}, 32'(Busy), 32'd1);
    check({tag, "_nodone_eval"}, 32'(Done), 32'd0);
    for (int i = 0; i < stall; i++) begin
      Load_CC = 1'b1;
      NZP     = (i == stall - 1) ? nzp : 3'($urandom);
      step();
      Start = noise ? 1'($urandom) : 1'b0;
      check({tag, "_nodone_stall"}, 32'(Done), 32'd0);
    end
    Load_CC   = 1'b0;
    NZP       = nzp;
    Clr_Stats = clr;
    step();
    Clr_Stats = 1'b0;
    Start     = noise ? 1'($urandom) : 1'b0;
    NZP       = 3'($urandom);
    if (clr) begin
      br_total    = 0;
      taken_total = 0;
    end else if (!exp_err) begin
      br_total++;
      if (exp_ben) taken_total++;
    end
    check({tag, "_done"},    32'(Done),    32'd1);
    check({tag, "_ld_pc"},   32'(LD_PC),   32'(exp_ben && !exp_err));
    check({tag, "_err"},     32'(Err),     32'(exp_err));
    check({tag, "_ben"},     32'(BEN),     32'(exp_ben));
    check({tag, "_pc_next"}, 32'(PC_Next), 32'(exp_pcn));
    check({tag, "_d4_res"},  {d4_done, d4_ld_pc, d4_err, d4_ben, d4_pc_next},
                             {1'b1, exp_ben && !exp_err, exp_err, exp_ben, exp_pcn});
    check_cnts(tag);
    step();
    Start = 1'b0;
    check({tag, "_done_off"}, {Done, LD_PC, Err, Busy, d4_busy}, 32'd0);
    check({tag, "_hold"},     {BEN, PC_Next}, {exp_ben, exp_pcn});
  endtask

  initial begin
    bit          m_ben;
    bit          m_err;
    logic [15:0] m_pcn;
    logic [15:0] rir;
    logic [15:0] rpc;
    logic [2:0]  rnzp;

    vecs[0]  = '{16'h0A05, 16'h3001, 3'b001, 0, 1'b1, 16'h3006, 1'b0};
    vecs[1]  = '{16'h05FF, 16'h0000, 3'b010, 0, 1'b1, 16'hFFFF, 1'b0};
    vecs[2]  = '{16'h05FF, 16'h0000, 3'b100, 0, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{16'h0201, 16'h1234, 3'b001, 3, 1'b1, 16'h1235, 1'b0};
    vecs[4]  = '{16'h1021, 16'h4000, 3'b111, 0, 1'b0, 16'h4000, 1'b1};
    vecs[5]  = '{16'h0010, 16'h2000, 3'b111, 1, 1'b0, 16'h2000, 1'b0};
    vecs[6]  = '{16'h0E10, 16'h2000, 3'b100, 0, 1'b1, 16'h2010, 1'b0};
    vecs[7]  = '{16'h0E10, 16'h2000, 3'b000, 2, 1'b0, 16'h2000, 1'b0};
    vecs[8]  = '{16'h0500, 16'h0100, 3'b010, 0, 1'b1, 16'h0000, 1'b0};
    vecs[9]  = '{16'h08FF, 16'hFFF0, 3'b100, 0, 1'b1, 16'h00EF, 1'b0};
    vecs[10] = '{16'hC1C0, 16'h5555, 3'b111, 0, 1'b0, 16'h5555, 1'b1};

    Reset = 1'b0; Start = 1'b0; IR = '0; PC = '0; NZP = '0;
    Load_CC = 1'b0; Clr_Stats = 1'b0;
    repeat (2) step();
    check("reset_state", {BEN, PC_Next, LD_PC, Done, Busy, Err, Br_Cnt, Taken_Cnt}, 32'd0);
    Reset = 1'b1;
    step();

    // Directed vector table.
    foreach (vecs[i]) begin
      run_txn($sformatf("vec%0d", i), vecs[i].ir, vecs[i].pc, vecs[i].nzp, vecs[i].stall,
              1'b1, 1'b0, vecs[i].ben, vecs[i].pcn, vecs[i].err);
    end

    // Async reset in the middle of a stalled EVAL.
    IR = 16'h0A05; PC = 16'h3001; NZP = 3'b001; Load_CC = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    check("pre_reset_busy", 32'(Busy), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("midreset_outs", {BEN, PC_Next, LD_PC, Done, Busy, Err}, 32'd0);
    check("midreset_cnts", {Br_Cnt, Taken_Cnt}, 32'd0);
    check("midreset_d4",   {d4_busy, d4_br_cnt, d4_taken_cnt}, 32'd0);
    @(posedge Clk);
    #1;
    Reset   = 1'b1;
    Load_CC = 1'b0;
    br_total    = 0;
    taken_total = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_reset_idle", {Done, LD_PC, Busy}, 32'd0);
    end

    // Back-to-back: Start held high gives one result every 3 cycles.
    IR = 16'h0E01; PC = 16'h1000; NZP = 3'b001; Start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("b2b_done_c%0d", c), 32'(Done), 32'((c % 3) == 2));
    end
    Start = 1'b0;
    br_total    += 3;
    taken_total += 3;
    check("b2b_pc_next", 32'(PC_Next), 32'h1001);
    check_cnts("b2b");

    // Saturation / wrap on the 4-bit instance.
    br_total    = 0;
    taken_total = 0;
    Clr_Stats   = 1'b1;
    step();
    Clr_Stats = 1'b0;
    check_cnts("idle_clr");
    for (int n = 0; n < 20; n++) begin
      rpc  = 16'($urandom);
      rnzp = 3'b001 << ($urandom % 3);
      run_txn("sat", 16'h0E01, rpc, rnzp, 0, 1'b1, 1'b0, 1'b1, rpc + 16'd1, 1'b0);
    end
    check("sat_taken4", 32'(d4_taken_cnt), 32'hF);
    check("wrap_br4",   32'(d4_br_cnt),    32'h4);
    check("sat_br16",   32'(Br_Cnt),       32'd20);
    run_txn("clr_with_taken", 16'h0E01, 16'h0100, 3'b010, 1, 1'b0, 1'b1, 1'b1, 16'h0101, 1'b0);
    check("clr_zero", {Br_Cnt, Taken_Cnt, 4'd0, 4'd0, d4_br_cnt, d4_taken_cnt}, 32'd0);

    // Randomized transactions against the model.
    for (int n = 0; n < 150; n++) begin
      rir = 16'($urandom);
      if (($urandom % 5) != 0) rir[15:12] = 4'd0;
      rpc  = 16'($urandom);
      rnzp = 3'($urandom);
      model(rir, rpc, rnzp, m_ben, m_pcn, m_err);
      run_txn("rand", rir, rpc, rnzp, int'($urandom % 4), 1'b1, (($urandom % 25) == 0),
              m_ben, m_pcn, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
